// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one req/gnt/rvalid memory bus between the fetch stage (instr_*) and
// the load/store unit (data_*). Data wins ties; a request that is not granted
// locks the bus to its owner until mem_gnt_i. Accepted transactions are tracked
// in an in-order route FIFO so every mem_rvalid_i is returned to its owner.
// Fetch responses can be discarded in flight with instr_flush_i.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   instr_req_i/addr_i        fetch request (address only, full-word read)
//   instr_gnt_o               fetch request accepted this cycle
//   instr_rvalid_o/rdata_o/err_o  fetch response
//   instr_flush_i             drop responses of all outstanding fetches
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request
//   data_gnt_o                LSU request accepted this cycle
//   data_rvalid_o/rdata_o/err_o   LSU response
//   mem_req_o/we_o/be_o/addr_o/wdata_o   bus request
//   mem_gnt_i, mem_rvalid_i/rdata_i/err_i bus handshake and response
//
// Build option
//   ARB_STARVE_GUARD_EN  when defined, after STARVE_LIMIT consecutive data
//                        grants with fetch waiting, fetch gets the next
//                        unlocked arbitration. Undefined: strict data priority.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        instr_flush_i,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic OWN_INSTR = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7)
   begin : g_param_check
      $error("mem_port_arbiter: MAX_OUTSTANDING must be 1..4, STARVE_LIMIT 1..7");
   end

   logic [CW-1:0]              cnt_q, cnt_d;
   logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   // Route FIFO: one owner bit and one discard bit per slot
   logic [MAX_OUTSTANDING-1:0] own_q, own_d, disc_q, disc_d;
   logic                       locked_q, locked_d, lock_own_q, lock_own_d;
   logic                       full, owner, grant, push, pop;
   logic                       head_own, head_disc, starve_hit;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full      = (cnt_q == CW'(MAX_OUTSTANDING));
      mem_req_o = (~full & (instr_req_i | data_req_i)) | locked_q;

      if (locked_q)                      owner = lock_own_q;
      else if (starve_hit & instr_req_i) owner = OWN_INSTR;
      else if (data_req_i)               owner = OWN_DATA;
      else                               owner = OWN_INSTR;

      grant       = mem_req_o & mem_gnt_i;
      instr_gnt_o = grant & (owner == OWN_INSTR);
      data_gnt_o  = grant & (owner == OWN_DATA);

      // Payload comes straight from the owning port; the owner holds it stable while locked
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (mem_req_o) begin
         if (owner == OWN_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
         end
      end

      head_own  = own_q[rd_ptr_q];
      head_disc = disc_q[rd_ptr_q];
      push      = grant & ~full;
      pop       = mem_rvalid_i & (cnt_q != '0);

      // A flush in the same cycle as a fetch response also drops that response
      instr_rvalid_o = pop & (head_own == OWN_INSTR) & ~head_disc & ~instr_flush_i;
      data_rvalid_o  = pop & (head_own == OWN_DATA);
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
      instr_err_o    = instr_rvalid_o & mem_err_i;
      data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
      data_err_o     = data_rvalid_o  & mem_err_i;

      locked_d   = mem_req_o & ~mem_gnt_i;
      lock_own_d = locked_d ? owner : lock_own_q;

      own_d  = own_q;
      disc_d = disc_q;
      // Instr entries carry owner bit 0; stale slots are rewritten on push
      if (instr_flush_i) disc_d = disc_q | ~own_q;
      if (push) begin
         own_d[wr_ptr_q]  = owner;
         disc_d[wr_ptr_q] = (owner == OWN_INSTR) & instr_flush_i;
      end
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         own_q      <= '0;
         disc_q     <= '0;
         locked_q   <= 1'b0;
         lock_own_q <= OWN_INSTR;
      end else begin
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         own_q      <= own_d;
         disc_q     <= disc_d;
         locked_q   <= locked_d;
         lock_own_q <= lock_own_d;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   // Counts data grants taken while fetch is waiting; saturates at the limit
   always_comb begin
      starve_d = starve_q;
      if (!instr_req_i || instr_gnt_o)
         starve_d = 3'd0;
      else if (data_gnt_o && starve_q != 3'(STARVE_LIMIT))
         starve_d = starve_q + 3'd1;
   end

   assign starve_hit = (starve_q == 3'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) starve_q <= 3'd0;
      else       starve_q <= starve_d;
   end
`else
   assign starve_hit = 1'b0;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rstn && mem_rvalid_i)
         assert (cnt_q != '0) else $error("mem_port_arbiter: mem_rvalid_i with no outstanding transaction");
   end
`endif

endmodule
